// File: rtl/nbit_spi_pkg.sv
// Shared SPI buffer definitions: FSM state encoding, byte width and counter width
// used by both the MISO receive buffer and the MOSI transmit buffer.
package nbit_spi_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // Requested byte count limited to the buffer capacity.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] req,
                                                     input int unsigned        max_n);
        if (32'(req) > max_n) return CNT_W'(max_n);
        return req;
    endfunction

endpackage

// File: rtl/nbit_miso_spi_buffer_if.sv
// Host-side bus of the MISO receive buffer: request, serial input and assembled results.
interface nbit_miso_spi_buffer_if #(
    parameter int unsigned WIDTH = nbit_spi_pkg::BYTE_W,
    parameter int unsigned N     = 8
);
    import nbit_spi_pkg::*;

    logic                 i_START;
    logic [CNT_W-1:0]     i_N_receive;
    logic                 i_MISO;
    logic [WIDTH*N-1:0]   o_DATA;
    logic                 o_VALID;
    logic [WIDTH-1:0]     o_BYTE;
    logic                 o_BYTE_VALID;
    logic                 o_BUSY;
    logic                 o_MISO_FINAL_BYTE;

    modport master (
        output i_START, i_N_receive, i_MISO,
        input  o_DATA, o_VALID, o_BYTE, o_BYTE_VALID, o_BUSY, o_MISO_FINAL_BYTE
    );

    modport slave (
        input  i_START, i_N_receive, i_MISO,
        output o_DATA, o_VALID, o_BYTE, o_BYTE_VALID, o_BUSY, o_MISO_FINAL_BYTE
    );

endinterface

// File: rtl/miso_byte_shifter.sv
// Serial-to-parallel byte shifter with bit counter; flags the edge that completes a byte.
// NBIT_MISO_LSB_FIRST_EN selects LSB-first bit order (default MSB-first).
module miso_byte_shifter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clear_i,
    input  logic             shift_en_i,
    input  logic             miso_i,
    output logic             byte_done_c_o,
    output logic [WIDTH-1:0] byte_c_o
);

    localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] sr_q, sr_d, shifted_c;
    logic [BIT_W-1:0] cnt_q, cnt_d;
    logic             last_bit_c;

`ifdef NBIT_MISO_LSB_FIRST_EN
    assign shifted_c = {miso_i, sr_q[WIDTH-1:1]};
`else
    assign shifted_c = {sr_q[WIDTH-2:0], miso_i};
`endif

    assign last_bit_c    = (cnt_q == BIT_W'(WIDTH - 1));
    assign byte_done_c_o = shift_en_i && last_bit_c;
    assign byte_c_o      = shifted_c;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (shift_en_i) begin
            sr_d  = shifted_c;
            cnt_d = last_bit_c ? '0 : cnt_q + BIT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nbit_miso_spi_buffer.sv
// MISO receive buffer: assembles up to N serial bytes into one word, first byte at the LSB.
// Bit order inside each byte follows NBIT_MISO_LSB_FIRST_EN (see miso_byte_shifter).
module nbit_miso_spi_buffer
    import nbit_spi_pkg::*;
#(
    parameter int unsigned WIDTH = BYTE_W,
    parameter int unsigned N     = 8
) (
    input  logic                   i_SCK,
    input  logic                   i_RST,
    nbit_miso_spi_buffer_if.slave  bus
);

    localparam int unsigned WORD_W = WIDTH * N;

    state_e            state_q;
    logic [CNT_W-1:0]  n_q, byte_cnt_q, n_clamped_c;
    logic [WORD_W-1:0] word_q, word_next_c, data_q;
    logic [WIDTH-1:0]  byte_q, shift_byte_c;
    logic              valid_q, byte_valid_q, busy_q, final_q;
    logic              byte_done_c, start_ok_c, receiving_c;

    assign receiving_c = (state_q == ST_RECEIVE);
    assign n_clamped_c = clamp_count(bus.i_N_receive, N);
    assign start_ok_c  = !receiving_c && bus.i_START && (bus.i_N_receive != '0);

    miso_byte_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk_i         (i_SCK),
        .rst_n_i       (i_RST),
        .clear_i       (start_ok_c),
        .shift_en_i    (receiving_c),
        .miso_i        (bus.i_MISO),
        .byte_done_c_o (byte_done_c),
        .byte_c_o      (shift_byte_c)
    );

    // Word as it will look once the byte in flight lands in its slot.
    always_comb begin
        word_next_c = word_q;
        for (int j = 0; j < int'(N); j++) begin
            if (byte_cnt_q == CNT_W'(j)) word_next_c[j*WIDTH +: WIDTH] = shift_byte_c;
        end
    end

    always_ff @(posedge i_SCK) begin
        if (!i_RST) begin
            state_q      <= ST_IDLE;
            n_q          <= '0;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            data_q       <= '0;
            byte_q       <= '0;
            valid_q      <= 1'b0;
            byte_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            final_q      <= 1'b0;
        end else begin
            valid_q      <= 1'b0;
            byte_valid_q <= 1'b0;
            case (state_q)
                ST_RECEIVE: begin
                    if (byte_done_c) begin
                        word_q       <= word_next_c;
                        byte_q       <= shift_byte_c;
                        byte_valid_q <= 1'b1;
                        byte_cnt_q   <= byte_cnt_q + CNT_W'(1);
                        if (byte_cnt_q + CNT_W'(1) == n_q) begin
                            data_q  <= word_next_c;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b0;
                            final_q <= 1'b0;
                            state_q <= ST_DONE;
                        end else if (byte_cnt_q + CNT_W'(2) == n_q) begin
                            final_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request; DONE otherwise falls back to IDLE.
                    if (start_ok_c) begin
                        state_q    <= ST_RECEIVE;
                        n_q        <= n_clamped_c;
                        byte_cnt_q <= '0;
                        word_q     <= '0;
                        busy_q     <= 1'b1;
                        final_q    <= (n_clamped_c == CNT_W'(1));
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.o_DATA            = data_q;
    assign bus.o_VALID           = valid_q;
    assign bus.o_BYTE            = byte_q;
    assign bus.o_BYTE_VALID      = byte_valid_q;
    assign bus.o_BUSY            = busy_q;
    assign bus.o_MISO_FINAL_BYTE = final_q;

endmodule

// File: tb/tb_nbit_miso_spi_buffer.sv
// Directed bench for nbit_miso_spi_buffer: vector table of transactions plus reset,
// zero-count, back-to-back and mid-transaction reset sequences.
module tb_nbit_miso_spi_buffer;

    localparam int unsigned W  = 8;
    localparam int unsigned NB = 8;
`ifdef NBIT_MISO_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    nbit_miso_spi_buffer_if #(.WIDTH(W), .N(NB)) bus ();

    nbit_miso_spi_buffer #(.WIDTH(W), .N(NB)) dut (
        .i_SCK (clk),
        .i_RST (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // tx: byte j in [8j +: 8], written so its MSB is the first bit sent on MISO.
    typedef struct {
        logic [4:0]  n;
        int          k;
        logic [63:0] tx;
        logic [63:0] exp_msb;
        logic [63:0] exp_lsb;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start at E0 then feed 8*k bits, checking every output after every edge.
    task automatic run_txn(input int vi, input logic [4:0] n, input int k,
                           input logic [63:0] tx, input logic [63:0] exp);
        bus.i_START     = 1'b1;
        bus.i_N_receive = n;
        bus.i_MISO      = 1'b0;
        for (int c = 0; c <= 8 * k; c++) begin
            if (c > 0) begin
                bus.i_START = 1'b0;
                bus.i_MISO  = tx[8 * ((c - 1) / 8) + 7 - ((c - 1) % 8)];
            end
            step();
            chk($sformatf("v%0d c%0d busy", vi, c), 64'(bus.o_BUSY), 64'(c < 8 * k));
            chk($sformatf("v%0d c%0d valid", vi, c), 64'(bus.o_VALID), 64'(c == 8 * k));
            chk($sformatf("v%0d c%0d byte_valid", vi, c), 64'(bus.o_BYTE_VALID),
                64'(c > 0 && c % 8 == 0));
            chk($sformatf("v%0d c%0d final_byte", vi, c), 64'(bus.o_MISO_FINAL_BYTE),
                64'(c >= 8 * (k - 1) && c < 8 * k));
            if (c > 0 && c % 8 == 0)
                chk($sformatf("v%0d c%0d byte", vi, c), 64'(bus.o_BYTE),
                    64'(exp[(c / 8 - 1) * 8 +: 8]));
            if (c == 8 * k)
                chk($sformatf("v%0d data", vi), bus.o_DATA, exp);
        end
    endtask

    function automatic logic [63:0] pick(input vec_t v);
        return LSB_FIRST ? v.exp_lsb : v.exp_msb;
    endfunction

    initial begin
        vecs[0] = '{5'd1,  1, 64'h00000000000000A5, 64'h00000000000000A5, 64'h00000000000000A5};
        vecs[1] = '{5'd3,  3, 64'h0000000000563412, 64'h0000000000563412, 64'h00000000006A2C48};
        vecs[2] = '{5'd20, 8, 64'h0807060504030201, 64'h0807060504030201, 64'h10E060A020C04080};
        vecs[3] = '{5'd2,  2, 64'h0000000000000180, 64'h0000000000000180, 64'h0000000000008001};
        vecs[4] = '{5'd1,  1, 64'h0000000000000080, 64'h0000000000000080, 64'h0000000000000001};

        // Reset held with a pending request.
        rst             = 1'b0;
        bus.i_START     = 1'b1;
        bus.i_N_receive = 5'd1;
        bus.i_MISO      = 1'b1;
        repeat (3) step();
        chk("rst data", bus.o_DATA, 64'h0);
        chk("rst valid", 64'(bus.o_VALID), 64'h0);
        chk("rst byte", 64'(bus.o_BYTE), 64'h0);
        chk("rst byte_valid", 64'(bus.o_BYTE_VALID), 64'h0);
        chk("rst busy", 64'(bus.o_BUSY), 64'h0);
        chk("rst final_byte", 64'(bus.o_MISO_FINAL_BYTE), 64'h0);
        bus.i_START = 1'b0;
        rst         = 1'b1;
        step();
        chk("post-rst busy", 64'(bus.o_BUSY), 64'h0);

        // Table of complete transactions, each followed by the DONE->IDLE cycle.
        for (int i = 0; i < 5; i++) begin
            run_txn(i, vecs[i].n, vecs[i].k, vecs[i].tx, pick(vecs[i]));
            bus.i_START = 1'b0;
            step();
            chk($sformatf("v%0d idle busy", i), 64'(bus.o_BUSY), 64'h0);
            chk($sformatf("v%0d idle valid", i), 64'(bus.o_VALID), 64'h0);
            chk($sformatf("v%0d held data", i), bus.o_DATA, pick(vecs[i]));
        end

        // Zero byte count is ignored.
        bus.i_START     = 1'b1;
        bus.i_N_receive = 5'd0;
        repeat (3) begin
            step();
            chk("n0 busy", 64'(bus.o_BUSY), 64'h0);
            chk("n0 valid", 64'(bus.o_VALID), 64'h0);
        end
        bus.i_START = 1'b0;
        chk("n0 held data", bus.o_DATA, pick(vecs[4]));

        // Back-to-back: second request lands on the DONE cycle of the first.
        run_txn(10, 5'd1, 1, vecs[0].tx, pick(vecs[0]));
        run_txn(11, 5'd2, 2, vecs[3].tx, pick(vecs[3]));
        bus.i_START = 1'b0;
        step();
        chk("b2b idle busy", 64'(bus.o_BUSY), 64'h0);

        // Reset on bit 13 of a 3-byte read discards everything.
        bus.i_START     = 1'b1;
        bus.i_N_receive = 5'd3;
        step();
        bus.i_START = 1'b0;
        for (int b = 1; b <= 12; b++) begin
            bus.i_MISO = vecs[1].tx[8 * ((b - 1) / 8) + 7 - ((b - 1) % 8)];
            step();
        end
        chk("mid busy before rst", 64'(bus.o_BUSY), 64'h1);
        rst = 1'b0;
        step();
        chk("mid rst data", bus.o_DATA, 64'h0);
        chk("mid rst byte", 64'(bus.o_BYTE), 64'h0);
        chk("mid rst busy", 64'(bus.o_BUSY), 64'h0);
        chk("mid rst final_byte", 64'(bus.o_MISO_FINAL_BYTE), 64'h0);
        rst = 1'b1;
        for (int c = 0; c < 30; c++) begin
            bus.i_MISO = 1'($urandom_range(0, 1));
            step();
            chk($sformatf("post-mid c%0d valid", c), 64'(bus.o_VALID), 64'h0);
            chk($sformatf("post-mid c%0d busy", c), 64'(bus.o_BUSY), 64'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
